if_stage: RTL and testbench

- Instruction-fetch stage. Owns the fetch PC and issues word fetches to instruction memory over a req/gnt/rvalid interface.
- Buffers returned instructions with their PCs and presents them to if_id_reg through a valid/ready handshake.
- Takes the jump/branch redirect from the execute stage and discards all wrong-path fetches.

---
 rtl/if_stage.sv | 167 ++++++++++++++++
 tb/tb_if_stage.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues req/gnt/rvalid word fetches,
// buffers returned instructions with their PCs and squashes wrong-path fetches on redirect.
//   state | meaning
//   RUN   | no discarded fetches pending
//   DRAIN | discard > 0, responses of pre-redirect fetches are being dropped
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_jump_en_i,
  input  logic [31:0] ex_jump_addr_i,
  input  logic        id_ready_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {RUN, DRAIN} state_t;

  state_t          state_q, state_d;
  logic            drain;

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     tag_q [BUF_DEPTH];
  logic [31:0]     tag_d [BUF_DEPTH];
  logic [PW-1:0]   tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [CW-1:0]   out_cnt_q, out_cnt_d;
  logic [CW-1:0]   discard_q, discard_d;

  logic [31:0]     buf_pc_q   [BUF_DEPTH];
  logic [31:0]     buf_pc_d   [BUF_DEPTH];
  logic [31:0]     buf_inst_q [BUF_DEPTH];
  logic [31:0]     buf_inst_d [BUF_DEPTH];
  logic [PW-1:0]   buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;
  logic [CW-1:0]   buf_cnt_q, buf_cnt_d;

  logic [CW-1:0]   occ;
  logic            gnt_fire, rsp_fire, buf_push, buf_pop;
  logic [31:0]     jump_tgt;

  assign occ         = out_cnt_q + buf_cnt_q;
  assign imem_req_o  = !rst && (occ < CW'(BUF_DEPTH));
  assign imem_addr_o = fetch_pc_q;
  assign jump_tgt    = ex_jump_addr_i & ~32'h3;

  assign if_valid_o  = (buf_cnt_q != '0);
  assign if_pc_o     = if_valid_o ? buf_pc_q[buf_rd_q]   : RESET_PC;
  assign if_inst_o   = if_valid_o ? buf_inst_q[buf_rd_q] : NOP_INST;

  // A response with nothing outstanding is a stray (e.g. from before reset) and is ignored.
  assign gnt_fire = imem_req_o && imem_gnt_i;
  assign rsp_fire = imem_rvalid_i && (out_cnt_q != '0);
  assign buf_push = rsp_fire && !drain && !ex_jump_en_i;
  assign buf_pop  = if_valid_o && id_ready_i && !ex_jump_en_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (ex_jump_en_i && out_cnt_d != '0) state_d = DRAIN;
      DRAIN: begin
        if (ex_jump_en_i)                                state_d = (out_cnt_d != '0) ? DRAIN : RUN;
        else if (rsp_fire && discard_q == CW'(1))        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    drain = (state_q == DRAIN);
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    tag_d      = tag_q;
    tag_wr_d   = tag_wr_q;
    tag_rd_d   = tag_rd_q;
    discard_d  = discard_q;
    buf_pc_d   = buf_pc_q;
    buf_inst_d = buf_inst_q;
    buf_wr_d   = buf_wr_q;
    buf_rd_d   = buf_rd_q;
    buf_cnt_d  = buf_cnt_q;

    // The tag queue tracks every issued fetch regardless of redirects so tags stay in order.
    if (gnt_fire) begin
      tag_d[tag_wr_q] = fetch_pc_q;
      tag_wr_d        = tag_wr_q + PW'(1);
    end
    if (rsp_fire) tag_rd_d = tag_rd_q + PW'(1);
    out_cnt_d = out_cnt_q + CW'(gnt_fire) - CW'(rsp_fire);

    if (ex_jump_en_i) begin
      fetch_pc_d = jump_tgt;
      buf_wr_d   = '0;
      buf_rd_d   = '0;
      buf_cnt_d  = '0;
      discard_d  = out_cnt_d;
    end else begin
      if (gnt_fire)          fetch_pc_d = fetch_pc_q + 32'd4;
      if (rsp_fire && drain) discard_d  = discard_q - CW'(1);
      if (buf_push) begin
        buf_pc_d[buf_wr_q]   = tag_q[tag_rd_q];
        buf_inst_d[buf_wr_q] = imem_rdata_i;
        buf_wr_d             = buf_wr_q + PW'(1);
      end
      if (buf_pop) buf_rd_d = buf_rd_q + PW'(1);
      buf_cnt_d = buf_cnt_q + CW'(buf_push) - CW'(buf_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      out_cnt_q  <= '0;
      discard_q  <= '0;
      buf_wr_q   <= '0;
      buf_rd_q   <= '0;
      buf_cnt_q  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        tag_q[i]      <= '0;
        buf_pc_q[i]   <= '0;
        buf_inst_q[i] <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      tag_q      <= tag_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
      out_cnt_q  <= out_cnt_d;
      discard_q  <= discard_d;
      buf_pc_q   <= buf_pc_d;
      buf_inst_q <= buf_inst_d;
      buf_wr_q   <= buf_wr_d;
      buf_rd_q   <= buf_rd_d;
      buf_cnt_q  <= buf_cnt_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (drain == (discard_q != '0));
      assert (occ <= CW'(BUF_DEPTH));
      assert (discard_q <= out_cnt_q);
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Randomised bench for if_stage: an in-order memory model plus a queue-based
// scoreboard of live fetches and presented instructions.
module tb_if_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          BUF_DEPTH = 2;
  localparam logic [31:0] NOP_INST  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_jump_en_i;
  logic [31:0] ex_jump_addr_i;
  logic        id_ready_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;

  if_stage #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH), .NOP_INST(NOP_INST)) dut (
    .clk(clk), .rst(rst),
    .ex_jump_en_i(ex_jump_en_i), .ex_jump_addr_i(ex_jump_addr_i),
    .id_ready_i(id_ready_i),
    .if_valid_o(if_valid_o), .if_pc_o(if_pc_o), .if_inst_o(if_inst_o),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    bit          live;
  } fetch_t;

  fetch_t      model_if[$];
  logic [31:0] model_buf[$];
  logic [31:0] model_pc;
  logic [31:0] mem_q[$];
  int          n_chk  = 0;
  int          n_pass = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   {31'b0, imem_req_o}, 32'd0);
    chk({tag, "_addr"},  imem_addr_o, RESET_PC);
    chk({tag, "_valid"}, {31'b0, if_valid_o}, 32'd0);
    chk({tag, "_pc"},    if_pc_o, RESET_PC);
    chk({tag, "_inst"},  if_inst_o, NOP_INST);
  endtask

  // One clock: check DUT against model, drive inputs, advance model and memory across the edge.
  task automatic step(input bit jmp, input logic [31:0] jaddr, input bit rdy, input bit g, input bit rv_allow);
    bit     exp_req, g_fire, rv;
    fetch_t e;
    @(negedge clk);
    exp_req = (model_if.size() + model_buf.size()) < BUF_DEPTH;
    chk("req",   {31'b0, imem_req_o}, {31'b0, exp_req});
    chk("addr",  imem_addr_o, model_pc);
    chk("valid", {31'b0, if_valid_o}, {31'b0, model_buf.size() != 0});
    if (model_buf.size() != 0) begin
      chk("pc",   if_pc_o,   model_buf[0]);
      chk("inst", if_inst_o, mem_word(model_buf[0]));
    end else begin
      chk("nop",  if_inst_o, NOP_INST);
    end

    rv             = rv_allow && (mem_q.size() != 0);
    ex_jump_en_i   = jmp;
    ex_jump_addr_i = jaddr;
    id_ready_i     = rdy;
    imem_gnt_i     = g;
    imem_rvalid_i  = rv;
    imem_rdata_i   = rv ? mem_word(mem_q[0]) : $urandom;
    #1;

    if (rv) void'(mem_q.pop_front());
    if (imem_req_o && g) mem_q.push_back(imem_addr_o);

    g_fire = exp_req && g;
    if (!jmp && rdy && model_buf.size() != 0) void'(model_buf.pop_front());
    if (rv && model_if.size() != 0) begin
      e = model_if.pop_front();
      if (!jmp && e.live) model_buf.push_back(e.pc);
    end
    if (g_fire) model_if.push_back('{pc: model_pc, live: 1'b1});
    if (jmp) begin
      model_buf.delete();
      foreach (model_if[i]) model_if[i].live = 1'b0;
      model_pc = jaddr & ~32'h3;
    end else if (g_fire) begin
      model_pc = model_pc + 32'd4;
    end
    @(posedge clk);
  endtask

  task automatic rand_steps(input int n, input int jmp_per_64);
    for (int i = 0; i < n; i++)
      step($urandom_range(63) < jmp_per_64, $urandom, $urandom_range(3) != 0,
           $urandom_range(3) != 0, $urandom_range(2) != 0);
  endtask

  task automatic idle_inputs();
    ex_jump_en_i   = 1'b0;
    ex_jump_addr_i = '0;
    id_ready_i     = 1'b0;
    imem_gnt_i     = 1'b0;
    imem_rvalid_i  = 1'b0;
    imem_rdata_i   = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_pc = RESET_PC;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("por");
    rst = 1'b0;

    // streaming, single-cycle memory
    repeat (12) step(0, '0, 1, 1, 1);
    // back-pressure then release
    repeat (5)  step(0, '0, 0, 1, 1);
    repeat (6)  step(0, '0, 1, 1, 1);
    // grant withheld
    repeat (3)  step(0, '0, 1, 0, 1);
    repeat (4)  step(0, '0, 1, 1, 1);
    // drain, issue two fetches, redirect while both are outstanding
    repeat (4)  step(0, '0, 1, 0, 1);
    repeat (2)  step(0, '0, 1, 1, 0);
    step(1, 32'h0000_1002, 1, 0, 0);
    repeat (8)  step(0, '0, 1, 1, 1);
    // redirect coinciding with grant and rvalid, then a second redirect
    repeat (2)  step(0, '0, 1, 1, 1);
    step(1, 32'h0000_1500, 1, 1, 1);
    step(1, 32'h0000_2000, 1, 1, 1);
    repeat (8)  step(0, '0, 1, 1, 1);

    rand_steps(3000, 4);

    // mid-stream reset with fetches outstanding
    repeat (2) step(0, '0, 1, 1, 0);
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid_rst");
    model_if.delete();
    model_buf.delete();
    model_pc = RESET_PC;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    // stale responses from before reset arrive with nothing outstanding
    repeat (3) step(0, '0, 1, 0, 1);
    mem_q.delete();
    repeat (10) step(0, '0, 1, 1, 1);

    rand_steps(1500, 8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
